// File: rtl/mmio_req_arbiter.sv
`default_nettype none
// ============================================================================
// mmio_req_arbiter : two-master round-robin arbiter onto one MMIO strobe port,
//                    one request in flight, watchdog-terminated on slave stall.
// Revision 1.0
// ============================================================================
module mmio_req_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic                    m0_req_we,
    input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
    input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_req_wmask,
    output logic                    m0_resp_valid,
    output logic [DATA_WIDTH-1:0]   m0_resp_rdata,
    output logic                    m0_resp_err,
    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic                    m1_req_we,
    input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
    input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_req_wmask,
    output logic                    m1_resp_valid,
    output logic [DATA_WIDTH-1:0]   m1_resp_rdata,
    output logic                    m1_resp_err,
    output logic                    mem_ren,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_valid,
    output logic                    busy
);

    localparam int MASK_W   = DATA_WIDTH / 8;
    localparam int CNT_W    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int TERM_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TERM_INT);
    localparam bit   WDOG_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic                    owner_q, owner_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]       wmask_q, wmask_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic w_any;
    logic w_win;
    logic w_idle;
    logic w_in_busy;
    logic w_in_resp;

    assign w_any     = m0_req_valid | m1_req_valid;
    // Contention resolved by prio; otherwise the lone valid requester wins.
    assign w_win     = (m0_req_valid & m1_req_valid) ? prio_q : m1_req_valid;
    assign w_idle    = (state_q == S_IDLE);
    assign w_in_busy = (state_q == S_BUSY);
    assign w_in_resp = (state_q == S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    owner_d = w_win;
                    we_d    = w_win ? m1_req_we    : m0_req_we;
                    addr_d  = w_win ? m1_req_addr  : m0_req_addr;
                    wdata_d = w_win ? m1_req_wdata : m0_req_wdata;
                    wmask_d = w_win ? m1_req_wmask : m0_req_wmask;
                    prio_d  = ~w_win;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // A completion in the terminal cycle beats the watchdog.
                if (mem_valid) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (WDOG_EN && (cnt_q == CNT_TERM)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m0_req_ready  = w_idle & w_any & ~w_win & ~rst;
    assign m1_req_ready  = w_idle & w_any &  w_win & ~rst;

    assign mem_ren   = w_in_busy & ~we_q;
    assign mem_wen   = w_in_busy &  we_q;
    assign mem_addr  = w_in_busy ? addr_q  : '0;
    assign mem_wdata = w_in_busy ? wdata_q : '0;
    assign mem_wmask = w_in_busy ? wmask_q : '0;

    assign m0_resp_valid = w_in_resp & ~owner_q;
    assign m0_resp_rdata = (w_in_resp & ~owner_q) ? rdata_q : '0;
    assign m0_resp_err   = w_in_resp & ~owner_q & err_q;
    assign m1_resp_valid = w_in_resp &  owner_q;
    assign m1_resp_rdata = (w_in_resp & owner_q) ? rdata_q : '0;
    assign m1_resp_err   = w_in_resp &  owner_q & err_q;

    assign busy = w_in_busy | w_in_resp;

endmodule
`default_nettype wire

// File: tb/tb_mmio_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mmio_req_arbiter : directed self-checking bench for mmio_req_arbiter.
// Revision 1.0
// ============================================================================
module tb_mmio_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [63:0] m0_req_addr, m0_req_wdata;
    logic [7:0]  m0_req_wmask;
    logic        m0_resp_valid, m0_resp_err;
    logic [63:0] m0_resp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [63:0] m1_req_addr, m1_req_wdata;
    logic [7:0]  m1_req_wmask;
    logic        m1_resp_valid, m1_resp_err;
    logic [63:0] m1_resp_rdata;
    logic        mem_ren, mem_wen, mem_valid, busy;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_req_arbiter #(
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req_valid  (m0_req_valid),
        .m0_req_ready  (m0_req_ready),
        .m0_req_we     (m0_req_we),
        .m0_req_addr   (m0_req_addr),
        .m0_req_wdata  (m0_req_wdata),
        .m0_req_wmask  (m0_req_wmask),
        .m0_resp_valid (m0_resp_valid),
        .m0_resp_rdata (m0_resp_rdata),
        .m0_resp_err   (m0_resp_err),
        .m1_req_valid  (m1_req_valid),
        .m1_req_ready  (m1_req_ready),
        .m1_req_we     (m1_req_we),
        .m1_req_addr   (m1_req_addr),
        .m1_req_wdata  (m1_req_wdata),
        .m1_req_wmask  (m1_req_wmask),
        .m1_resp_valid (m1_resp_valid),
        .m1_resp_rdata (m1_resp_rdata),
        .m1_resp_err   (m1_resp_err),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rdata     (mem_rdata),
        .mem_valid     (mem_valid),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_req_valid = 0; m0_req_we = 0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_wmask = '0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_wmask = '0;
        mem_valid = 0; mem_rdata = '0;
        settle();
        chk("reset_busy",   busy, 0);
        chk("reset_ren",    mem_ren, 0);
        chk("reset_resp0",  m0_resp_valid, 0);
        chk("reset_ready0", m0_req_ready, 0);
        tick();
        rst = 1'b0;

        // Single read, slave answers 3 cycles after the first strobe cycle
        m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 64'h0200_BFF8;
        settle();
        chk("rd_ready0", m0_req_ready, 1);
        chk("rd_ready1", m1_req_ready, 0);
        tick();
        m0_req_valid = 0;
        settle();
        chk("rd_ren_t1",   mem_ren, 1);
        chk("rd_wen_t1",   mem_wen, 0);
        chk("rd_addr",     mem_addr, 64'h0200_BFF8);
        chk("rd_busy",     busy, 1);
        chk("rd_noready",  m0_req_ready, 0);
        tick();
        chk("rd_ren_t2", mem_ren, 1);
        tick();
        chk("rd_ren_t3", mem_ren, 1);
        tick();
        mem_valid = 1; mem_rdata = 64'h1234;
        settle();
        chk("rd_ren_t4",      mem_ren, 1);
        chk("rd_noresp_t4",   m0_resp_valid, 0);
        tick();
        mem_valid = 0; mem_rdata = '0;
        settle();
        chk("rd_resp_valid0", m0_resp_valid, 1);
        chk("rd_resp_rdata0", m0_resp_rdata, 64'h1234);
        chk("rd_resp_err0",   m0_resp_err, 0);
        chk("rd_resp_valid1", m1_resp_valid, 0);
        chk("rd_ren_resp",    mem_ren, 0);
        chk("rd_busy_resp",   busy, 1);
        tick();
        chk("rd_resp_gone", m0_resp_valid, 0);
        chk("rd_idle_busy", busy, 0);

        // Round-robin contention from reset: m0, m1, m0, m1
        rst = 1'b1;
        m0_req_valid = 1; m0_req_addr = 64'h100;
        m1_req_valid = 1; m1_req_addr = 64'h200; m1_req_we = 0;
        settle();
        tick();
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            settle();
            chk("rr_ready0", m0_req_ready, (g % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_ready1", m1_req_ready, (g % 2 == 1) ? 64'd1 : 64'd0);
            tick();
            mem_valid = 1; mem_rdata = 64'hA0 + 64'(g);
            settle();
            chk("rr_addr", mem_addr, (g % 2 == 0) ? 64'h100 : 64'h200);
            chk("rr_ren",  mem_ren, 1);
            tick();
            mem_valid = 0; mem_rdata = '0;
            settle();
            chk("rr_resp0", m0_resp_valid, (g % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_resp1", m1_resp_valid, (g % 2 == 1) ? 64'd1 : 64'd0);
            chk("rr_rdata", (g % 2 == 0) ? m0_resp_rdata : m1_resp_rdata, 64'hA0 + 64'(g));
            chk("rr_other_rdata", (g % 2 == 0) ? m1_resp_rdata : m0_resp_rdata, 64'h0);
            tick();
        end
        m0_req_valid = 0; m1_req_valid = 0;

        // Write from m1; mem_rdata garbage must not reach the response
        m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 64'h300;
        m1_req_wdata = 64'hDEAD_BEEF; m1_req_wmask = 8'h0F;
        settle();
        chk("wr_ready1", m1_req_ready, 1);
        chk("wr_ready0", m0_req_ready, 0);
        tick();
        m1_req_valid = 0;
        mem_valid = 1; mem_rdata = 64'hFFFF;
        settle();
        chk("wr_wen",   mem_wen, 1);
        chk("wr_ren",   mem_ren, 0);
        chk("wr_wdata", mem_wdata, 64'hDEAD_BEEF);
        chk("wr_wmask", mem_wmask, 64'h0F);
        chk("wr_addr",  mem_addr, 64'h300);
        tick();
        mem_valid = 0; mem_rdata = '0;
        settle();
        chk("wr_resp1",  m1_resp_valid, 1);
        chk("wr_rdata",  m1_resp_rdata, 0);
        chk("wr_err",    m1_resp_err, 0);
        chk("wr_resp0",  m0_resp_valid, 0);
        chk("wr_wen_off", mem_wen, 0);
        tick();

        // Timeout: slave silent, strobe held 8 cycles then error response
        m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 64'h400;
        settle();
        chk("to_ready0", m0_req_ready, 1);
        tick();
        m0_req_valid = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            chk("to_ren_held", mem_ren, 1);
            chk("to_no_resp",  m0_resp_valid, 0);
            tick();
        end
        settle();
        chk("to_ren_off", mem_ren, 0);
        chk("to_resp0",   m0_resp_valid, 1);
        chk("to_err",     m0_resp_err, 1);
        chk("to_rdata",   m0_resp_rdata, 0);
        tick();

        // Next request accepted; mem_valid coincides with watchdog expiry
        m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 64'h500;
        settle();
        chk("co_ready1", m1_req_ready, 1);
        tick();
        m1_req_valid = 0;
        for (int c = 0; c < 7; c++) tick();
        mem_valid = 1; mem_rdata = 64'h5555;
        settle();
        chk("co_ren_last", mem_ren, 1);
        tick();
        mem_valid = 0; mem_rdata = '0;
        settle();
        chk("co_resp1", m1_resp_valid, 1);
        chk("co_err",   m1_resp_err, 0);
        chk("co_rdata", m1_resp_rdata, 64'h5555);
        tick();

        // Stray mem_valid in IDLE
        mem_valid = 1; mem_rdata = 64'h7777;
        tick();
        mem_valid = 0; mem_rdata = '0;
        settle();
        chk("stray_resp0", m0_resp_valid, 0);
        chk("stray_resp1", m1_resp_valid, 0);
        chk("stray_busy",  busy, 0);

        // Reset while BUSY, then contention resolves to m0 first
        m0_req_valid = 1; m0_req_addr = 64'h600;
        tick();
        m0_req_valid = 0;
        settle();
        chk("mr_ren_before", mem_ren, 1);
        rst = 1'b1;
        m0_req_valid = 1; m0_req_addr = 64'h700;
        m1_req_valid = 1; m1_req_addr = 64'h800;
        settle();
        chk("mr_ren",    mem_ren, 0);
        chk("mr_addr",   mem_addr, 0);
        chk("mr_busy",   busy, 0);
        chk("mr_ready0", m0_req_ready, 0);
        tick();
        chk("mr_resp0", m0_resp_valid, 0);
        rst = 1'b0;
        settle();
        chk("mr_first0", m0_req_ready, 1);
        chk("mr_first1", m1_req_ready, 0);
        tick();
        settle();
        chk("mr_grant_addr", mem_addr, 64'h700);
        m0_req_valid = 0; m1_req_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
